// File: rtl/pd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pd_sequencer_pkg
// Shared types and widths for the peak-detection sequencer slice.
//   BIN_W    : width of a range-bin index (up to 15 bins per shot)
//   ADDR_W   : width of a peak position inside one range bin
//   VALUE_W  : width of a peak magnitude
//   seqState_e : sequencer FSM states (IDLE, RUN, OUT)
//   slot_t   : one stored peak result {value, addr}
// ---------------------------------------------------------------------------
package pd_sequencer_pkg;

    localparam int BIN_W   = 4;
    localparam int ADDR_W  = 10;
    localparam int VALUE_W = 32;
    localparam int SLOT_W  = VALUE_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } seqState_e;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [ADDR_W-1:0]  addr;
    } slot_t;

endpackage

// File: rtl/pd_sequencer_if.sv
// ---------------------------------------------------------------------------
// pd_sequencer_if
// Result handshake bundle between the sequencer and its consumer.
//   res_valid  : result payload is valid
//   res_ready  : consumer accepts the payload this cycle
//   res_value  : peak magnitude of the bin being reported
//   res_addr   : peak position within the bin
//   res_bin    : index of the bin being reported
//   res_last   : this is the final bin of the shot
// Modports: master (sequencer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface pd_sequencer_if;
    import pd_sequencer_pkg::*;

    logic               res_valid;
    logic               res_ready;
    logic [VALUE_W-1:0] res_value;
    logic [ADDR_W-1:0]  res_addr;
    logic [BIN_W-1:0]   res_bin;
    logic               res_last;

    modport master (
        output res_valid,
        output res_value,
        output res_addr,
        output res_bin,
        output res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_value,
        input  res_addr,
        input  res_bin,
        input  res_last,
        output res_ready
    );

endinterface

// File: rtl/pd_result_buf.sv
// ---------------------------------------------------------------------------
// pd_result_buf
// Small register file holding one peak result per range bin of a shot.
// One synchronous write port, one asynchronous read port. Contents are not
// reset: every slot is rewritten before it is read in a new shot.
//   clk   : system clock
//   we    : write enable
//   waddr : slot written when we=1
//   wdata : result written
//   raddr : slot read
//   rdata : result currently held in slot raddr (0 if out of range)
// ---------------------------------------------------------------------------
module pd_result_buf
    import pd_sequencer_pkg::*;
#(
    parameter int DEPTH = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BIN_W-1:0] waddr,
    input  slot_t            wdata,
    input  logic [BIN_W-1:0] raddr,
    output slot_t            rdata
);

    slot_t mem [DEPTH];

    // Write port; addresses beyond the configured depth are dropped.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the sequencer can register the payload
    // in the same cycle it advances its read pointer.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/pd_sequencer.sv
// ---------------------------------------------------------------------------
// pd_sequencer
// Sequences one shot of peak detection: on start it enables the peak
// datapath, captures one peak result per range bin, then streams the stored
// results out over a valid/ready handshake. A shot that does not finish
// within TIMEOUT_CYCLES is abandoned with a sticky timeout flag.
//
// Optional feature (macro PD_SEQ_THRESH_EN): results whose magnitude is
// below 'thresh' are stored as value 0 / addr 0. Without the macro results
// are stored unmodified and 'thresh' is ignored.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   start       : one-cycle pulse, accumulated shot ready
//   pd_en       : enable to the peak-detection datapath (high while RUN)
//   pk_valid    : one-cycle strobe, peak of current bin valid
//   pk_value    : peak magnitude
//   pk_addr     : peak position within the bin
//   thresh      : minimum accepted magnitude (PD_SEQ_THRESH_EN only)
//   res         : result handshake (pd_sequencer_if.master)
//   busy        : high in RUN and OUT
//   done        : one-cycle pulse at end of shot (completed or timed out)
//   err_timeout : sticky, set when RUN timed out; cleared by next start
// ---------------------------------------------------------------------------
module pd_sequencer
    import pd_sequencer_pkg::*;
#(
    parameter int TOTAL_RANGEBIN  = 9,
    parameter int RANGE_IN_POINTS = 1024,
    parameter int TIMEOUT_CYCLES  = 16384
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               pd_en,
    input  logic               pk_valid,
    input  logic [VALUE_W-1:0] pk_value,
    input  logic [ADDR_W-1:0]  pk_addr,
    input  logic [VALUE_W-1:0] thresh,
    pd_sequencer_if.master     res,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(TOTAL_RANGEBIN - 1);
    // The timer reaches TIMEOUT_CYCLES-1 on the edge that leaves this value,
    // so the abort is taken while the registered count is one below that.
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 2);

    // Elaboration-time parameter sanity checks.
    if (RANGE_IN_POINTS != (1 << ADDR_W)) begin : gBadRangePoints
        $error("pd_sequencer: RANGE_IN_POINTS must equal 2**ADDR_W");
    end
    if ((TOTAL_RANGEBIN < 1) || (TOTAL_RANGEBIN > 15)) begin : gBadBinCount
        $error("pd_sequencer: TOTAL_RANGEBIN must be within 1..15");
    end
    if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
        $error("pd_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    seqState_e          state_q;
    logic [BIN_W-1:0]   count_q;
    logic [BIN_W-1:0]   rdPtr_q;
    logic [TMR_W-1:0]   timer_q;
    logic               pdEn_q;
    logic               busy_q;
    logic               done_q;
    logic               errTimeout_q;
    logic               resValid_q;
    logic [VALUE_W-1:0] resValue_q;
    logic [ADDR_W-1:0]  resAddr_q;
    logic [BIN_W-1:0]   resBin_q;
    logic               resLast_q;

    logic               wrEn;
    slot_t              wrData;
    slot_t              rdData;
    slot_t              loadData;
    logic [BIN_W-1:0]   rdAddr;
    logic [BIN_W-1:0]   rdPtrNext;
    logic               runDone;
    logic               runTimeout;
    logic               xfer;

    // Capture only happens in RUN; the bin that fills the last slot ends
    // the run, and that completion beats a simultaneous timeout.
    assign wrEn       = (state_q == RUN) && pk_valid;
    assign runDone    = wrEn && (count_q == LAST_BIN);
    assign runTimeout = (state_q == RUN) && (timer_q == TMR_LIMIT) && !runDone;
    assign xfer       = resValid_q && res.res_ready;
    assign rdPtrNext  = rdPtr_q + BIN_W'(1);

`ifdef PD_SEQ_THRESH_EN
    // Weak peaks are squashed to zero but still occupy their bin slot.
    always_comb begin
        wrData.value = pk_value;
        wrData.addr  = pk_addr;
        if (pk_value < thresh) begin
            wrData = '0;
        end
    end
`else
    // Results pass through untouched; thresh has no effect in this build.
    always_comb begin
        wrData.value = pk_value;
        wrData.addr  = pk_addr;
    end

    logic unusedThresh;
    assign unusedThresh = ^thresh;
`endif

    // Select the slot that feeds the payload register on the next edge, and
    // bypass the write port when that slot is being written in the same
    // cycle (only happens with a single-bin shot).
    always_comb begin
        rdAddr = '0;
        if (state_q == OUT) begin
            rdAddr = xfer ? rdPtrNext : rdPtr_q;
        end
        loadData = rdData;
        if (wrEn && (count_q == rdAddr)) begin
            loadData = wrData;
        end
    end

    pd_result_buf #(
        .DEPTH (TOTAL_RANGEBIN)
    ) u_buf (
        .clk   (clk),
        .we    (wrEn),
        .waddr (count_q),
        .wdata (wrData),
        .raddr (rdAddr),
        .rdata (rdData)
    );

    // Main sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rdPtr_q      <= '0;
            timer_q      <= '0;
            pdEn_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            errTimeout_q <= 1'b0;
            resValid_q   <= 1'b0;
            resValue_q   <= '0;
            resAddr_q    <= '0;
            resBin_q     <= '0;
            resLast_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        count_q      <= '0;
                        rdPtr_q      <= '0;
                        timer_q      <= '0;
                        errTimeout_q <= 1'b0;
                        pdEn_q       <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end

                RUN: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (wrEn) begin
                        count_q <= count_q + BIN_W'(1);
                    end
                    if (runDone) begin
                        state_q    <= OUT;
                        pdEn_q     <= 1'b0;
                        rdPtr_q    <= '0;
                        resValid_q <= 1'b1;
                        resValue_q <= loadData.value;
                        resAddr_q  <= loadData.addr;
                        resBin_q   <= '0;
                        resLast_q  <= (LAST_BIN == '0);
                    end else if (runTimeout) begin
                        state_q      <= IDLE;
                        pdEn_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        errTimeout_q <= 1'b1;
                    end
                end

                OUT: begin
                    if (xfer) begin
                        if (resLast_q) begin
                            state_q    <= IDLE;
                            resValid_q <= 1'b0;
                            resLast_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            rdPtr_q    <= rdPtrNext;
                            resBin_q   <= rdPtrNext;
                            resValue_q <= loadData.value;
                            resAddr_q  <= loadData.addr;
                            resLast_q  <= (rdPtrNext == LAST_BIN);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pd_en         = pdEn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_timeout   = errTimeout_q;
    assign res.res_valid = resValid_q;
    assign res.res_value = resValue_q;
    assign res.res_addr  = resAddr_q;
    assign res.res_bin   = resBin_q;
    assign res.res_last  = resLast_q;

endmodule

// File: tb/tb_pd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pd_sequencer
// Directed bench for pd_sequencer. dutA uses default parameters; dutB uses a
// short 64-cycle timeout so the abort path can be exercised quickly. Both
// share reset and the peak inputs; each has its own start and handshake.
// Expected results honour PD_SEQ_THRESH_EN when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pd_sequencer;
    import pd_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        startB = 1'b0;
    logic        pk_valid = 1'b0;
    logic [31:0] pk_value = '0;
    logic [9:0]  pk_addr = '0;
    logic [31:0] thresh = 32'd500;

    logic pd_en, busy, done, err_timeout;
    logic pdEnB, busyB, doneB, errB;

    int vectors = 0;
    int miscompares = 0;

    pd_sequencer_if ifA ();
    pd_sequencer_if ifB ();

    pd_sequencer dutA (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pd_en       (pd_en),
        .pk_valid    (pk_valid),
        .pk_value    (pk_value),
        .pk_addr     (pk_addr),
        .thresh      (thresh),
        .res         (ifA),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    pd_sequencer #(
        .TIMEOUT_CYCLES (64)
    ) dutB (
        .clk         (clk),
        .rst         (rst),
        .start       (startB),
        .pd_en       (pdEnB),
        .pk_valid    (pk_valid),
        .pk_value    (pk_value),
        .pk_addr     (pk_addr),
        .thresh      (thresh),
        .res         (ifB),
        .busy        (busyB),
        .done        (doneB),
        .err_timeout (errB)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Global safety net so the run can never hang.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected stored magnitude of bin i.
    function automatic logic [31:0] expVal(input int i);
        logic [31:0] v;
        v = 32'(100 * i);
`ifdef PD_SEQ_THRESH_EN
        if (v < 32'd500) v = '0;
`endif
        return v;
    endfunction

    // Expected stored position of bin i.
    function automatic logic [9:0] expAddr(input int i);
        logic [9:0] a;
        a = 10'(512 + i);
`ifdef PD_SEQ_THRESH_EN
        if (32'(100 * i) < 32'd500) a = '0;
`endif
        return a;
    endfunction

    // One comparison: count it, and report a failure if it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs to dutA (from a falling edge), then clear strobes.
    task automatic applyStimulus(input logic st, input logic pv,
                                 input logic [31:0] val, input logic [9:0] addr);
        start    = st;
        pk_valid = pv;
        pk_value = val;
        pk_addr  = addr;
        @(negedge clk);
        start    = 1'b0;
        pk_valid = 1'b0;
    endtask

    // Send n peak strobes, one every 'spacing' cycles, values 100*i / 512+i.
    task automatic feedShot(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            repeat (spacing - 1) @(negedge clk);
            applyStimulus(1'b0, 1'b1, 32'(100 * i), 10'(512 + i));
        end
    endtask

    // Drain one shot from dutA, checking each payload against bin order.
    task automatic collectShot(input string name, input bit stall, input bit junk);
        int k;
        int guard;
        logic rdy;
        k = 0;
        guard = 0;
        while (ifA.res_valid !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_first_valid"}, 64'(ifA.res_valid), 64'd1);
        checkOutput({name, "_pd_en_out"}, 64'(pd_en), 64'd0);
        checkOutput({name, "_busy_out"}, 64'(busy), 64'd1);
        guard = 0;
        while (k < 9 && guard < 100) begin
            checkOutput($sformatf("%s_valid[%0d]", name, k), 64'(ifA.res_valid), 64'd1);
            checkOutput($sformatf("%s_bin[%0d]", name, k), 64'(ifA.res_bin), 64'(k));
            checkOutput($sformatf("%s_value[%0d]", name, k), 64'(ifA.res_value), 64'(expVal(k)));
            checkOutput($sformatf("%s_addr[%0d]", name, k), 64'(ifA.res_addr), 64'(expAddr(k)));
            checkOutput($sformatf("%s_last[%0d]", name, k), 64'(ifA.res_last), 64'(k == 8));
            rdy = stall ? guard[0] : 1'b1;
            ifA.res_ready = rdy;
            if (junk) begin
                start    = 1'b1;
                pk_valid = 1'b1;
                pk_value = 32'hDEAD_BEEF;
                pk_addr  = 10'h3FF;
            end
            @(negedge clk);
            start    = 1'b0;
            pk_valid = 1'b0;
            if (rdy) k++;
            guard++;
        end
        checkOutput({name, "_transfers"}, 64'(k), 64'd9);
        checkOutput({name, "_done_pulse"}, 64'(done), 64'd1);
        checkOutput({name, "_valid_drop"}, 64'(ifA.res_valid), 64'd0);
        checkOutput({name, "_busy_drop"}, 64'(busy), 64'd0);
        ifA.res_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, "_done_clear"}, 64'(done), 64'd0);
        checkOutput({name, "_idle_valid"}, 64'(ifA.res_valid), 64'd0);
        checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        bit sawValid;

        ifA.res_ready = 1'b1;
        ifB.res_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_pd_en", 64'(pd_en), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err_timeout), 64'd0);
        checkOutput("rst_valid", 64'(ifA.res_valid), 64'd0);
        checkOutput("rst_last", 64'(ifA.res_last), 64'd0);
        checkOutput("rst_value", 64'(ifA.res_value), 64'd0);
        checkOutput("rst_addr", 64'(ifA.res_addr), 64'd0);
        checkOutput("rst_bin", 64'(ifA.res_bin), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full shot, slow peak rate, consumer always ready.
        $display("[TB] shot with 1025-cycle peak spacing");
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("s1_pd_en_run", 64'(pd_en), 64'd1);
        checkOutput("s1_busy_run", 64'(busy), 64'd1);
        checkOutput("s1_valid_run", 64'(ifA.res_valid), 64'd0);
        feedShot(9, 1025);
        collectShot("s1", 1'b0, 1'b0);

        // Consumer alternates ready 0/1.
        $display("[TB] shot with stalling consumer");
        applyStimulus(1'b1, 1'b0, '0, '0);
        feedShot(9, 2);
        collectShot("s2", 1'b1, 1'b0);

        // start and pk_valid held during OUT must be ignored.
        $display("[TB] shot with spurious start/pk_valid during output");
        applyStimulus(1'b1, 1'b0, '0, '0);
        feedShot(9, 2);
        collectShot("s3", 1'b0, 1'b1);

        // Timeout on dutB: only 5 peaks; dutA stays idle and ignores them.
        $display("[TB] timeout shot on 64-cycle instance");
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        checkOutput("to_pd_en_run", 64'(pdEnB), 64'd1);
        cyc = 0;
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (2) begin
                @(negedge clk);
                cyc++;
            end
            applyStimulus(1'b0, 1'b1, 32'(100 * i), 10'(512 + i));
            cyc++;
        end
        while (doneB !== 1'b1 && cyc < 200) begin
            if (ifB.res_valid === 1'b1) sawValid = 1'b1;
            @(negedge clk);
            cyc++;
        end
        checkOutput("to_done_cycle", 64'(cyc), 64'd63);
        checkOutput("to_done", 64'(doneB), 64'd1);
        checkOutput("to_err", 64'(errB), 64'd1);
        checkOutput("to_pd_en", 64'(pdEnB), 64'd0);
        checkOutput("to_busy", 64'(busyB), 64'd0);
        checkOutput("to_no_valid", 64'(sawValid | ifB.res_valid), 64'd0);
        checkOutput("idleA_pd_en", 64'(pd_en), 64'd0);
        checkOutput("idleA_busy", 64'(busy), 64'd0);
        checkOutput("idleA_valid", 64'(ifA.res_valid), 64'd0);
        @(negedge clk);
        checkOutput("to_done_clear", 64'(doneB), 64'd0);
        checkOutput("to_err_sticky", 64'(errB), 64'd1);

        // Reset after 4 captures abandons the shot.
        $display("[TB] reset in the middle of a shot");
        applyStimulus(1'b1, 1'b0, '0, '0);
        feedShot(4, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_pd_en", 64'(pd_en), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_valid", 64'(ifA.res_valid), 64'd0);
        checkOutput("mid_rst_value", 64'(ifA.res_value), 64'd0);
        checkOutput("mid_rst_addr", 64'(ifA.res_addr), 64'd0);
        checkOutput("mid_rst_bin", 64'(ifA.res_bin), 64'd0);
        checkOutput("mid_rst_last", 64'(ifA.res_last), 64'd0);
        checkOutput("mid_rst_errB", 64'(errB), 64'd0);
        @(negedge clk);
        checkOutput("post_rst_idle_busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("s4_pd_en_run", 64'(pd_en), 64'd1);
        feedShot(9, 2);
        collectShot("s4", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pd_sequencer.md
PD_SEQUENCER -- requirements
Module: pd_sequencer

Interface
REQ-001 TOTAL_RANGEBIN, default 9: range bins (peak results) per shot; 1..15.
REQ-002 RANGE_IN_POINTS, default 1024: points per range bin; sets the address width of 10 bits.
REQ-003 TIMEOUT_CYCLES, default 16384: maximum cycles allowed in RUN.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse: accumulated shot ready for peak search.
REQ-007 pd_en  out  1  enable to peak-detection datapath.
REQ-008 pk_valid  in  1  one-cycle strobe: peak result of current bin valid.
REQ-009 pk_value  in  32  peak magnitude; pk_addr  in  10  peak position within bin.
REQ-010 thresh  in  32  minimum accepted peak magnitude; used only with PD_SEQ_THRESH_EN.
REQ-011 res_valid  out  1, res_ready  in  1: result handshake.
REQ-012 res_value  out  32, res_addr  out  10, res_bin  out  4, res_last  out  1: result payload.
REQ-013 busy  out  1, done  out  1 (pulse), err_timeout  out  1 (sticky).

Function
REQ-014 FSM states SHALL be IDLE, RUN, OUT; encoding is free.
REQ-015 IDLE: start=1 -> RUN next cycle; capture count, read pointer and timeout counter SHALL be cleared; err_timeout SHALL be cleared.
REQ-016 pd_en SHALL be 1 exactly while state==RUN (registered, high the cycle after start).
REQ-017 RUN: each pk_valid SHALL write {pk_value,pk_addr} to slot[count]; count SHALL increment.
REQ-018 The write completing count==TOTAL_RANGEBIN SHALL move the FSM to OUT next cycle; pd_en low from that cycle.
REQ-019 pk_valid outside RUN SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-020 RUN timeout counter SHALL increment every cycle; at TIMEOUT_CYCLES-1 without completion: err_timeout=1, done pulse, -> IDLE, no results output.
REQ-021 Completion and timeout in the same cycle: completion SHALL win.
REQ-022 OUT: res_valid=1 with slot[rd_ptr]; res_bin=rd_ptr; res_last=1 when rd_ptr==TOTAL_RANGEBIN-1.
REQ-023 Payload SHALL be stable while res_valid=1 and res_ready=0; transfer on res_valid&&res_ready; rd_ptr increments.
REQ-024 Transfer with res_last=1: done pulses 1 cycle, res_valid low, FSM -> IDLE in the next cycle.
REQ-025 busy SHALL be 1 in RUN and OUT; max throughput one result per cycle.

Reset
REQ-026 rst=1 SHALL force IDLE; pd_en, res_valid, res_last, done, err_timeout, busy SHALL be 0; res_value, res_addr, res_bin SHALL be 0.
REQ-027 rst mid-RUN or mid-OUT SHALL abandon the shot; result slots need not be cleared.

Configuration
REQ-028 Macro PD_SEQ_THRESH_EN defined: a result with pk_value < thresh SHALL be stored with value 0 and addr 0 (bin still counted).
REQ-029 Macro PD_SEQ_THRESH_EN undefined: results SHALL be stored unmodified; thresh ignored.

Structure
REQ-030 Shared package SHALL hold the FSM state type, the bin index width (4) and the address width (10).
REQ-031 Result storage SHALL be one sub-module pd_result_buf (TOTAL_RANGEBIN x 42-bit register file, one write port, one read port).

Verification
REQ-032 start; 9 pk_valid every 1025 cycles with pk_value=100*i, pk_addr=512+i; res_ready=1 -> 9 transfers, res_bin 0..8, res_value 0..800, res_last on 8, done 1 cycle.
REQ-033 res_ready toggled 0/1 each cycle during OUT -> payload held while stalled, no result lost or duplicated, 9 transfers total.
REQ-034 Only 5 pk_valid, TIMEOUT_CYCLES=64 -> err_timeout=1 and done at 63 cycles after RUN entry, pd_en=0, res_valid never 1.
REQ-035 start and extra pk_valid during OUT -> ignored; output sequence unchanged.
REQ-036 rst asserted after 4 captures -> next cycle all outputs 0, IDLE; new start runs a full 9-bin shot correctly.
REQ-037 PD_SEQ_THRESH_EN defined, thresh=500, values 0..800 -> bins 0..4 report value 0/addr 0, bins 5..8 unchanged.
